// File: rtl/branch_predictor.sv
// branch_predictor: bimodal branch predictor with a mispredict flush FSM.
//   A table of 2^INDEX_W two-bit saturating counters is indexed by PC[INDEX_W+1:2].
//   Lookup is combinational. Updates from EX are written on the next clock edge.
//   A mispredicting update raises flush for FLUSH_CYCLES cycles. Updates that
//   arrive during flush belong to squashed instructions and are dropped.
// Ports:
//   clk, rst          - clock (rising edge), synchronous active-high reset
//   pred_pc           - IF-stage PC to look up
//   pred_taken        - prediction for pred_pc (counter MSB)
//   upd_valid/upd_pc  - resolved conditional branch and its PC
//   upd_taken         - actual outcome
//   upd_pred          - prediction that travelled down the pipe with the branch
//   mispredict        - combinational: accepted update whose outcome != prediction
//   flush             - registered: squash younger stages
//   mispred_cnt       - saturating 16-bit mispredict count
module branch_predictor #(
  parameter int INDEX_W      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred,
  output logic        mispredict,
  output logic        flush,
  output logic [15:0] mispred_cnt
);

  localparam int unsigned ENTRIES   = 2 ** INDEX_W;
  localparam logic [1:0]  FCNT_LOAD = 2'(FLUSH_CYCLES - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_fcnt;
  logic [1:0]         w_fcnt_nxt;
  logic [1:0]         r_bht [ENTRIES];
  logic [15:0]        r_mispred_cnt;
  logic [INDEX_W-1:0] w_pred_idx;
  logic [INDEX_W-1:0] w_upd_idx;
  logic [1:0]         w_upd_ctr;
  logic               w_accept;
  logic               w_mispredict;

  always_comb begin
    w_pred_idx   = pred_pc[INDEX_W+1:2];
    w_upd_idx    = upd_pc[INDEX_W+1:2];
    w_upd_ctr    = r_bht[w_upd_idx];
    w_accept     = upd_valid && (r_state == S_IDLE);
    w_mispredict = w_accept && (upd_taken != upd_pred);
  end

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign pred_taken  = r_bht[w_pred_idx][1];
  assign mispredict  = w_mispredict;
  assign mispred_cnt = r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_accept) begin
      if (upd_taken) begin
        if (w_upd_ctr != 2'b11) r_bht[w_upd_idx] <= w_upd_ctr + 2'b01;
      end else begin
        if (w_upd_ctr != 2'b00) r_bht[w_upd_idx] <= w_upd_ctr - 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mispred_cnt <= '0;
    end else if (w_mispredict && (r_mispred_cnt != '1)) begin
      r_mispred_cnt <= r_mispred_cnt + 16'd1;
    end
  end

  // Flush FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Flush FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_mispredict) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = FCNT_LOAD;
        end
      end
      S_FLUSH: begin
        if (r_fcnt != 2'd0) begin
          w_fcnt_nxt = r_fcnt - 2'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  // Flush FSM: outputs
  always_comb begin
    flush = (r_state == S_FLUSH);
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor. A behavioural model tracks the
// counters as integers, the flush window as a count of remaining cycles and
// the mispredict count as a clamped integer.
module tb_branch_predictor;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pred_pc = '0;
  logic        pred_taken;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred = 1'b0;
  logic        mispredict;
  logic        flush;
  logic [15:0] mispred_cnt;

  int total = 0;
  int bad   = 0;

  int m_ctr [16];
  int m_flush_left = 0;
  int m_cnt = 0;

  logic act_pred, act_misp, exp_pred, exp_misp;

  branch_predictor #(.INDEX_W(4), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .mispredict(mispredict), .flush(flush),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic int idx(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  // Drives one cycle from just after a falling edge, records the combinational
  // outputs against the model, advances the model at the rising edge and
  // returns at the next falling edge.
  task automatic cycle(input logic r, input logic [31:0] ppc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic up);
    bit acc;
    int k;
    rst = r; pred_pc = ppc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_pred = up;
    #1;
    act_pred = pred_taken;
    act_misp = mispredict;
    exp_pred = (m_ctr[idx(ppc)] >= 2);
    acc      = uv && (m_flush_left == 0);
    exp_misp = acc && (ut != up);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_flush_left = 0;
      m_cnt = 0;
    end else begin
      if (acc) begin
        k = idx(upc);
        if (ut) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
        else    m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
      end
      if (exp_misp) begin
        m_flush_left = FLUSH_CYCLES;
        if (m_cnt < 65535) m_cnt++;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    logic [31:0] pc;
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush); end
    total++;
    if (mispred_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL reset_cnt: got %0d want %0d", mispred_cnt, m_cnt); end
    // rst stays high while the table is swept, so extra edges keep it reset
    for (int k = 0; k < 16; k++) begin
      pc = {$urandom_range(0, 32'h03FF_FFFF), 4'(k), 2'($urandom_range(0, 3))};
      pred_pc = pc;
      #1;
      total++;
      if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred pc=%h: got %b want 0", pc, pred_taken); end
    end
    @(negedge clk);
    cycle(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (act_pred !== exp_pred) begin bad++; $display("FAIL reset_pred_40: got %b want %b", act_pred, exp_pred); end
  endtask

  task automatic test_train;
    cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1);
    cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1);
    cycle(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (act_pred !== exp_pred || exp_pred !== 1'b1) begin bad++; $display("FAIL train_pred: got %b want 1", act_pred); end
    total++;
    if (dut.r_bht[0] !== 2'(m_ctr[0])) begin bad++; $display("FAIL train_ctr: got %b want %0d", dut.r_bht[0], m_ctr[0]); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1);
    total++;
    if (dut.r_bht[0] !== 2'(m_ctr[0])) begin bad++; $display("FAIL sat_hi_ctr: got %b want %0d", dut.r_bht[0], m_ctr[0]); end
    cycle(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 1'b0);
    total++;
    if (dut.r_bht[0] !== 2'(m_ctr[0])) begin bad++; $display("FAIL sat_dec_ctr: got %b want %0d", dut.r_bht[0], m_ctr[0]); end
    cycle(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (act_pred !== exp_pred) begin bad++; $display("FAIL sat_pred: got %b want %b", act_pred, exp_pred); end
  endtask

  task automatic test_mispredict;
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0);
    total++;
    if (act_misp !== exp_misp || exp_misp !== 1'b1) begin bad++; $display("FAIL misp_comb: got %b want 1", act_misp); end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (flush !== (m_flush_left > 0)) begin bad++; $display("FAIL misp_flush c=%0d: got %b want %b", c, flush, m_flush_left > 0); end
      idle(1);
    end
    total++;
    if (mispred_cnt !== 16'(m_cnt) || m_cnt != 1) begin bad++; $display("FAIL misp_cnt: got %0d want 1", mispred_cnt); end
  endtask

  task automatic test_flush_drop;
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b0);
    cycle(1'b0, 32'h44, 1'b1, 32'h44, 1'b1, 1'b0);
    total++;
    if (act_misp !== exp_misp) begin bad++; $display("FAIL drop_misp: got %b want %b", act_misp, exp_misp); end
    total++;
    if (dut.r_bht[1] !== 2'(m_ctr[1])) begin bad++; $display("FAIL drop_ctr: got %b want %0d", dut.r_bht[1], m_ctr[1]); end
    total++;
    if (mispred_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL drop_cnt: got %0d want %0d", mispred_cnt, m_cnt); end
    idle(3);
  endtask

  task automatic test_same_cycle;
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    // 0x84 aliases 0x44; the update must not show until the next cycle
    cycle(1'b0, 32'h44, 1'b1, 32'h84, 1'b1, 1'b1);
    total++;
    if (act_pred !== exp_pred || exp_pred !== 1'b0) begin bad++; $display("FAIL same_old: got %b want 0", act_pred); end
    cycle(1'b0, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (act_pred !== exp_pred || exp_pred !== 1'b1) begin bad++; $display("FAIL same_new: got %b want 1", act_pred); end
    cycle(1'b0, 32'h84, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (act_pred !== exp_pred) begin bad++; $display("FAIL alias_84: got %b want %b", act_pred, exp_pred); end
  endtask

  task automatic test_reset_mid_flush;
    logic [31:0] pc;
    cycle(1'b0, 32'h0, 1'b1, 32'h48, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h48, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h4C, 1'b1, 1'b0);
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    total++;
    if (flush !== 1'b0) begin bad++; $display("FAIL rstfl_flush: got %b want 0", flush); end
    total++;
    if (mispred_cnt !== 16'd0) begin bad++; $display("FAIL rstfl_cnt: got %0d want 0", mispred_cnt); end
    for (int k = 0; k < 16; k++) begin
      pc = {26'($urandom), 4'(k), 2'b00};
      pred_pc = pc;
      #1;
      total++;
      if (pred_taken !== 1'b0) begin bad++; $display("FAIL rstfl_pred pc=%h: got %b want 0", pc, pred_taken); end
    end
    @(negedge clk);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_cnt_saturate;
    cycle(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    force dut.r_mispred_cnt = 16'hFFFD;
    #1;
    release dut.r_mispred_cnt;
    m_cnt = 65533;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0);
      total++;
      if (mispred_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL cnt_sat i=%0d: got %h want %h", i, mispred_cnt, 16'(m_cnt)); end
      idle(2);
    end
  endtask

  task automatic test_random;
    logic [31:0] pcs [5];
    logic [31:0] ppc, upc;
    logic r, uv;
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h80; pcs[3] = 32'h84; pcs[4] = 32'h1238;
    for (int n = 0; n < 400; n++) begin
      ppc = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 4)];
      upc = ($urandom_range(0, 3) == 0) ? $urandom : pcs[$urandom_range(0, 4)];
      r   = ($urandom_range(0, 49) == 0);
      uv  = !r && ($urandom_range(0, 2) != 0);
      cycle(r, ppc, uv, upc, 1'($urandom), 1'($urandom));
      total++;
      if (act_pred !== exp_pred) begin bad++; $display("FAIL rnd_pred n=%0d: got %b want %b", n, act_pred, exp_pred); end
      total++;
      if (act_misp !== exp_misp) begin bad++; $display("FAIL rnd_misp n=%0d: got %b want %b", n, act_misp, exp_misp); end
      total++;
      if (flush !== (m_flush_left > 0)) begin bad++; $display("FAIL rnd_flush n=%0d: got %b want %b", n, flush, m_flush_left > 0); end
      total++;
      if (mispred_cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt n=%0d: got %0d want %0d", n, mispred_cnt, m_cnt); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    @(negedge clk);
    test_reset();
    test_train();
    test_saturate();
    idle(3);
    test_mispredict();
    test_flush_drop();
    test_same_cycle();
    test_reset_mid_flush();
    test_cnt_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, meaning log2 of the branch history table (BHT) entry count (16 entries).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a mispredict (range 1-3).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pred_pc  input  32  IF-stage PC to look up.
REQ-006 SHALL have port pred_taken  output  1  prediction for pred_pc (1 = taken).
REQ-007 SHALL have port upd_valid  input  1  resolved conditional branch presented this cycle from EX.
REQ-008 SHALL have port upd_pc  input  32  PC of the resolved branch.
REQ-009 SHALL have port upd_taken  input  1  actual outcome (the branch unit's branchSignal).
REQ-010 SHALL have port upd_pred  input  1  prediction carried down the pipe with that branch.
REQ-011 SHALL have port mispredict  output  1  combinational, accepted update whose outcome differs from its prediction.
REQ-012 SHALL have port flush  output  1  registered, squash younger pipeline stages.
REQ-013 SHALL have port mispred_cnt  output  16  saturating mispredict count.

Function
REQ-014 SHALL hold 2^INDEX_W two-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-015 SHALL index the BHT with PC[INDEX_W+1:2] for both lookup and update; PC[1:0] and the upper bits SHALL be ignored (aliasing permitted).
REQ-016 SHALL drive pred_taken combinationally as the MSB of the indexed counter, with zero-cycle latency.
REQ-017 SHALL accept an update only when upd_valid=1 and the FSM is in IDLE; all other upd_valid pulses SHALL be dropped (squashed instructions).
REQ-018 SHALL, on an accepted update, increment the counter on the next clock edge if upd_taken=1 (saturating at 11) and decrement it if upd_taken=0 (saturating at 00).
REQ-019 SHALL NOT bypass a same-cycle update to the same index: lookup returns the pre-update value, and the new value is visible the following cycle.
REQ-020 SHALL assert mispredict = accepted update AND (upd_taken != upd_pred).
REQ-021 SHALL implement a flush FSM with two states: IDLE, and FLUSH with down-counter fcnt.
REQ-022 FSM transition IDLE->FLUSH SHALL occur on mispredict, loading fcnt=FLUSH_CYCLES-1.
REQ-023 FSM transition FLUSH->FLUSH SHALL occur while fcnt!=0, decrementing fcnt.
REQ-024 FSM transition FLUSH->IDLE SHALL occur when fcnt==0.
REQ-025 SHALL assert flush=1 exactly while in FLUSH, so flush is high for FLUSH_CYCLES cycles starting the cycle after mispredict.
REQ-026 SHALL increment mispred_cnt by 1 on each mispredict and saturate at 16'hFFFF with no wrap.
REQ-027 SHALL still update the counter on a mispredicting update, per REQ-018.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set every BHT counter to 01, FSM to IDLE, fcnt to 0, flush to 0 and mispred_cnt to 0.
REQ-029 SHALL give rst priority over any simultaneous update or FSM transition, including mid-FLUSH, where flush SHALL be 0 the cycle after reset.
REQ-030 SHALL drive pred_taken=0 for every PC after reset.

Verification
REQ-031 Bench SHALL cover: reset, then pred_pc=0x40 -> pred_taken=0; two accepted updates at upd_pc=0x40 with upd_taken=1 -> pred_taken=1 and counter=11.
REQ-032 Bench SHALL cover: five consecutive taken updates at 0x40, then one not-taken -> counter 11 then 10, and pred_taken stays 1.
REQ-033 Bench SHALL cover: update upd_pc=0x80, upd_taken=1, upd_pred=0 -> mispredict=1 same cycle, flush=1 for exactly 2 cycles after, mispred_cnt=1.
REQ-034 Bench SHALL cover: upd_valid=1 with a mismatch during FLUSH -> no mispredict, no counter change, mispred_cnt unchanged.
REQ-035 Bench SHALL cover: lookup and update of 0x44 in the same cycle -> old prediction returned, new value the next cycle; 0x44 and 0x84 alias to the same entry.
REQ-036 Bench SHALL cover: rst asserted during FLUSH -> flush=0, mispred_cnt=0 and all pred_taken=0 next cycle; mispred_cnt preloaded near 0xFFFF saturates at 0xFFFF.
